// File: rtl/posit_pkg.sv
// Shared types and constants for the posit non-computational unit.
package posit_pkg;

    typedef enum logic [2:0] {
        NC_SGNJ  = 3'd0,
        NC_SGNJN = 3'd1,
        NC_SGNJX = 3'd2,
        NC_MIN   = 3'd3,
        NC_MAX   = 3'd4,
        NC_EQ    = 3'd5,
        NC_LT    = 3'd6,
        NC_LE    = 3'd7
    } noncomp_op_e;

    // NaR pattern (sign bit only) for a posit of width n, right-aligned in 64 bits.
    function automatic logic [63:0] nar_val(input int unsigned n);
        return 64'(1) << (n - 1);
    endfunction

endpackage

// File: rtl/posit_pipe_stage.sv
// One valid/data register of an elastic pipeline with flush and ready chaining.
module posit_pipe_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // The stage can take new data when empty or when its content leaves this cycle.
    assign o_ready = !r_valid || i_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
        end
    end

    // NOTE: data is reset so the outputs read 0 after reset; flush leaves it untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data <= '0;
        end else if (o_ready && i_valid) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/posit_noncomp_pipe.sv
// Pipelined posit sign injection, MIN/MAX and EQ/LT/LE with valid/ready handshake.
module posit_noncomp_pipe
    import posit_pkg::*;
#(
    parameter int unsigned N         = 32,
    parameter int unsigned TAGW      = 4,
    parameter int unsigned PIPE_REGS = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  noncomp_op_e     op_i,
    input  logic [N-1:0]    operand_a_i,
    input  logic [N-1:0]    operand_b_i,
    input  logic [TAGW-1:0] tag_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [N-1:0]    result_o,
    output logic            nar_o,
    output logic [TAGW-1:0] tag_o,
    output logic            busy_o
);

    localparam int unsigned  PW  = N + 1 + TAGW;
    localparam logic [N-1:0] NAR = N'(nar_val(N));

    logic         w_sa;
    logic         w_sb;
    logic         w_t;
    logic [N-1:0] w_neg_a;
    logic         w_any_nar;
    logic         w_a_lt_b;
    logic         w_a_eq_b;
    logic [N-1:0] w_result;
    logic         w_nar;

    assign w_sa      = operand_a_i[N-1];
    assign w_sb      = operand_b_i[N-1];
    assign w_neg_a   = ~operand_a_i + N'(1);
    assign w_any_nar = (operand_a_i == NAR) || (operand_b_i == NAR);
    // Posits order as two's-complement integers, which puts NaR below everything.
    assign w_a_lt_b  = $signed(operand_a_i) < $signed(operand_b_i);
    assign w_a_eq_b  = operand_a_i == operand_b_i;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_result = operand_a_i;
        w_nar    = 1'b0;
        w_t      = w_sa;
        unique case (op_i)
            NC_SGNJ:  w_t = w_sb;
            NC_SGNJN: w_t = ~w_sb;
            NC_SGNJX: w_t = w_sa ^ w_sb;
            default:  w_t = w_sa;
        endcase
        case (op_i)
            NC_SGNJ, NC_SGNJN, NC_SGNJX: w_result = (w_t != w_sa) ? w_neg_a : operand_a_i;
            NC_MIN: begin
                w_nar    = w_any_nar;
                w_result = w_any_nar ? NAR : (w_a_lt_b || w_a_eq_b) ? operand_a_i : operand_b_i;
            end
            NC_MAX: begin
                w_nar    = w_any_nar;
                w_result = w_any_nar ? NAR : w_a_lt_b ? operand_b_i : operand_a_i;
            end
            NC_EQ:   w_result = {{(N-1){1'b0}}, w_a_eq_b};
            NC_LT:   w_result = {{(N-1){1'b0}}, w_a_lt_b};
            NC_LE:   w_result = {{(N-1){1'b0}}, w_a_lt_b || w_a_eq_b};
            default: w_result = operand_a_i;
        endcase
    end

    generate
        if (PIPE_REGS == 0) begin : g_comb
            logic w_unused_ctrl;
            assign w_unused_ctrl = clk_i ^ rst_ni ^ flush_i;
            assign in_ready_o    = out_ready_i;
            assign out_valid_o   = in_valid_i;
            assign result_o      = w_result;
            assign nar_o         = w_nar;
            assign tag_o         = tag_i;
            assign busy_o        = 1'b0;
        end else begin : g_pipe
            logic                 w_valid [PIPE_REGS+1];
            logic                 w_ready [PIPE_REGS+1];
            logic [PW-1:0]        w_data  [PIPE_REGS+1];
            logic [PIPE_REGS-1:0] w_busy;

            assign w_valid[0]         = in_valid_i;
            assign w_data[0]          = {w_result, w_nar, tag_i};
            assign w_ready[PIPE_REGS] = out_ready_i;
            assign in_ready_o         = w_ready[0];

            for (genvar k = 0; k < PIPE_REGS; k++) begin : g_stage
                posit_pipe_stage #(.W(PW)) u_stage (
                    .clk_i   (clk_i),
                    .rst_ni  (rst_ni),
                    .flush_i (flush_i),
                    .i_valid (w_valid[k]),
                    .o_ready (w_ready[k]),
                    .i_data  (w_data[k]),
                    .o_valid (w_valid[k+1]),
                    .i_ready (w_ready[k+1]),
                    .o_data  (w_data[k+1])
                );
                assign w_busy[k] = w_valid[k+1];
            end

            assign out_valid_o                = w_valid[PIPE_REGS];
            assign {result_o, nar_o, tag_o}   = w_data[PIPE_REGS];
            assign busy_o                     = |w_busy;
        end
    endgenerate

endmodule

// File: tb/tb_posit_noncomp_pipe.sv
// Self-checking bench for posit_noncomp_pipe at N=32, PIPE_REGS=2.
module tb_posit_noncomp_pipe;
    import posit_pkg::*;

    localparam logic [31:0] NAR = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    noncomp_op_e op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        nar;
    logic [3:0]  tag_out;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    posit_noncomp_pipe #(.N(32), .TAGW(4), .PIPE_REGS(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .operand_a_i (opa),
        .operand_b_i (opb),
        .tag_i       (tag_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .nar_o       (nar),
        .tag_o       (tag_out),
        .busy_o      (busy)
    );

    typedef struct {
        noncomp_op_e op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        nar;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        nar;
        logic [3:0]  tag;
    } exp_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: operands viewed as signed integers; sign injection negates A when its sign must change.
    function automatic void model(input noncomp_op_e o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic n);
        longint va = longint'($signed(a));
        longint vb = longint'($signed(b));
        bit     want_neg;
        n = 1'b0;
        r = a;
        case (o)
            NC_SGNJ, NC_SGNJN, NC_SGNJX: begin
                want_neg = (o == NC_SGNJ) ? (vb < 0) : (o == NC_SGNJN) ? !(vb < 0) : ((va < 0) != (vb < 0));
                if (want_neg != (va < 0)) r = 32'(-va);
            end
            NC_MIN: if (a == NAR || b == NAR) begin r = NAR; n = 1'b1; end
                    else r = (vb < va) ? b : a;
            NC_MAX: if (a == NAR || b == NAR) begin r = NAR; n = 1'b1; end
                    else r = (vb > va) ? b : a;
            NC_EQ:  r = (va == vb) ? 32'd1 : 32'd0;
            NC_LT:  r = (va <  vb) ? 32'd1 : 32'd0;
            NC_LE:  r = (va <= vb) ? 32'd1 : 32'd0;
            default: r = a;
        endcase
    endfunction

    function automatic logic [31:0] rand_posit();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return NAR;
            2:       return 32'h4000_0000;
            3:       return 32'hC000_0000;
            default: return $urandom();
        endcase
    endfunction

    // Single operation with no backpressure: output must appear exactly two edges later.
    task automatic send_and_check(input vec_t v, input logic [3:0] t, input string name);
        @(negedge clk);
        op = v.op; opa = v.a; opb = v.b; tag_in = t; in_valid = 1'b1;
        #1 check({name, " in_ready"}, 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        check({name, " early_valid"}, 64'(out_valid), 64'(0));
        @(negedge clk);
        check({name, " out_valid"}, 64'(out_valid), 64'(1));
        check({name, " result"}, 64'(result), 64'(v.res));
        check({name, " nar"}, 64'(nar), 64'(v.nar));
        check({name, " tag"}, 64'(tag_out), 64'(t));
    endtask

    // Streams n_ops through the pipe; directed mode uses tags 0.. and out_ready pattern 1,0,0,1.
    task automatic run_stream(input int n_ops, input bit directed, input string name);
        exp_t q[$];
        exp_t e;
        exp_t held;
        bit   prev_stall = 1'b0;
        int   sent = 0;
        int   recv = 0;
        int   cyc  = 0;
        int   limit = n_ops * 10 + 50;
        while (recv < n_ops && cyc < limit) begin
            @(negedge clk);
            if (prev_stall) begin
                check({name, " stall_valid"}, 64'(out_valid), 64'(1));
                check({name, " stall_hold"}, {31'd0, result, nar}, {31'd0, held.res, held.nar});
                check({name, " stall_tag"}, 64'(tag_out), 64'(held.tag));
            end
            out_ready = directed ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom_range(0, 1));
            in_valid  = (sent < n_ops) && (directed || $urandom_range(0, 3) != 0);
            op        = noncomp_op_e'($urandom_range(0, 7));
            opa       = rand_posit();
            opb       = ($urandom_range(0, 7) == 0) ? opa : rand_posit();
            tag_in    = directed ? 4'(sent) : 4'($urandom());
            #1;
            check({name, " in_ready"}, 64'(in_ready), 64'(!(q.size() == 2 && !out_ready)));
            check({name, " busy"}, 64'(busy), 64'(q.size() != 0));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check({name, " spurious_valid"}, 64'(out_valid), 64'(0));
                end else begin
                    e = q.pop_front();
                    check({name, " result"}, 64'(result), 64'(e.res));
                    check({name, " nar"}, 64'(nar), 64'(e.nar));
                    check({name, " tag"}, 64'(tag_out), 64'(e.tag));
                end
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            held = '{res: result, nar: nar, tag: tag_out};
            if (in_valid && in_ready) begin
                model(op, opa, opb, e.res, e.nar);
                e.tag = tag_in;
                q.push_back(e);
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({name, " completed"}, 64'(recv), 64'(n_ops));
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{NC_SGNJ,  32'h4000_0000, 32'hC000_0000, 32'hC000_0000, 1'b0};
        vecs[1]  = '{NC_SGNJX, 32'hC000_0000, 32'hC000_0000, 32'h4000_0000, 1'b0};
        vecs[2]  = '{NC_SGNJN, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{NC_SGNJ,  NAR,           32'h4000_0000, NAR,           1'b0};
        vecs[4]  = '{NC_MIN,   32'h4000_0000, 32'hC000_0000, 32'hC000_0000, 1'b0};
        vecs[5]  = '{NC_MAX,   NAR,           32'h4000_0000, NAR,           1'b1};
        vecs[6]  = '{NC_LT,    NAR,           32'hC000_0000, 32'h0000_0001, 1'b0};
        vecs[7]  = '{NC_EQ,    NAR,           NAR,           32'h0000_0001, 1'b0};
        vecs[8]  = '{NC_SGNJN, 32'h4000_0000, 32'h4000_0000, 32'hC000_0000, 1'b0};
        vecs[9]  = '{NC_MAX,   32'h4000_0000, 32'hC000_0000, 32'h4000_0000, 1'b0};
        vecs[10] = '{NC_MIN,   32'h1234_5678, NAR,           NAR,           1'b1};
        vecs[11] = '{NC_LT,    32'h4000_0000, 32'hC000_0000, 32'h0000_0000, 1'b0};
        vecs[12] = '{NC_LE,    32'hC000_0000, 32'hC000_0000, 32'h0000_0001, 1'b0};
        vecs[13] = '{NC_SGNJX, 32'h3000_0001, 32'h8000_0001, 32'hCFFF_FFFF, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = NC_SGNJ; opa = '0; opb = '0; tag_in = '0;

        #12;
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset in_ready", 64'(in_ready), 64'(1));
        check("reset result", {result, 27'd0, nar, tag_out}, 64'(0));

        for (int i = 0; i < 14; i++) begin
            send_and_check(vecs[i], 4'(i), $sformatf("vec%0d", i));
        end

        run_stream(6, 1'b1, "backpressure");
        run_stream(300, 1'b0, "random");

        // Flush with two ops in flight and a new input presented in the same cycle.
        @(negedge clk);
        op = NC_SGNJ; opa = 32'h4000_0000; opb = 32'h0; tag_in = 4'hA; in_valid = 1'b1;
        @(negedge clk);
        tag_in = 4'hB;
        @(negedge clk);
        check("flush pre busy", 64'(busy), 64'(1));
        flush = 1'b1; tag_in = 4'hC;
        #1 check("flush in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush out_valid", 64'(out_valid), 64'(0));
        check("flush busy", 64'(busy), 64'(0));
        @(negedge clk);
        check("flush dropped", 64'(out_valid), 64'(0));
        send_and_check(vecs[4], 4'h5, "post_flush");

        // Asynchronous reset with the pipe full and stalled.
        @(negedge clk);
        out_ready = 1'b0; op = NC_MAX; opa = 32'h4000_0000; opb = 32'h7000_0000; tag_in = 4'h7; in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("full out_valid", 64'(out_valid), 64'(1));
        check("full in_ready", 64'(in_ready), 64'(0));
        #2 rst_n = 1'b0;
        #1;
        check("async rst out_valid", 64'(out_valid), 64'(0));
        check("async rst busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post rst in_ready", 64'(in_ready), 64'(1));
        check("post rst outputs", {result, 27'd0, nar, tag_out}, 64'(0));
        check("post rst out_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        send_and_check(vecs[1], 4'h9, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
